// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: funct3 codes,
// FSM state encoding, special-case constants and operand signedness helpers.
package muldiv_pkg;

    localparam logic [2:0] F_MUL    = 3'd0;
    localparam logic [2:0] F_MULH   = 3'd1;
    localparam logic [2:0] F_MULHSU = 3'd2;
    localparam logic [2:0] F_MULHU  = 3'd3;
    localparam logic [2:0] F_DIV    = 3'd4;
    localparam logic [2:0] F_DIVU   = 3'd5;
    localparam logic [2:0] F_REM    = 3'd6;
    localparam logic [2:0] F_REMU   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;

    function automatic logic op_signed_a(input logic [2:0] f);
        return !(f == F_MULHU || f == F_DIVU || f == F_REMU);
    endfunction

    function automatic logic op_signed_b(input logic [2:0] f);
        return (f == F_MUL || f == F_MULH || f == F_DIV || f == F_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Radix-2 iterative datapath: shift-add multiply and restoring divide on
// magnitudes, sharing one hi/lo shift register pair, plus the final sign fix.
module muldiv_iter_core
    import muldiv_pkg::*;
#(
    parameter int NBits = 32
) (
    input  logic             clk,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [2:0]       funct3_i,
    input  logic [NBits-1:0] a_i,
    input  logic [NBits-1:0] b_i,
    output logic [NBits-1:0] res_o
);

    logic [NBits-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic [NBits-1:0] hi_n, lo_n;
    logic [2:0]       f3_q, f3_d;
    logic             neg_q, neg_d, rneg_q, rneg_d, bz_q, bz_d;
    logic             sa, sb;
    logic [NBits:0]   sum, rsh, diff;
    logic [2*NBits-1:0] prod;
    logic [NBits-1:0] quo, rem;

    function automatic logic [NBits-1:0] cond_neg(input logic c, input logic [NBits-1:0] v);
        return c ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*NBits-1:0] cond_neg2(input logic c, input logic [2*NBits-1:0] v);
        return c ? (~v + 1'b1) : v;
    endfunction

    // One iteration: hi is accumulator/partial remainder, lo is multiplier/quotient.
    always_comb begin
        sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
        rsh  = {hi_q, lo_q[NBits-1]};
        diff = rsh - {1'b0, opnd_q};
        if (f3_q[2]) begin
            if (!diff[NBits]) begin
                hi_n = diff[NBits-1:0];
                lo_n = {lo_q[NBits-2:0], 1'b1};
            end else begin
                hi_n = rsh[NBits-1:0];
                lo_n = {lo_q[NBits-2:0], 1'b0};
            end
        end else begin
            hi_n = sum[NBits:1];
            lo_n = {sum[0], lo_q[NBits-1:1]};
        end
    end

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        opnd_d = opnd_q;
        f3_d   = f3_q;
        neg_d  = neg_q;
        rneg_d = rneg_q;
        bz_d   = bz_q;
        sa     = op_signed_a(funct3_i) & a_i[NBits-1];
        sb     = op_signed_b(funct3_i) & b_i[NBits-1];
        if (load_i) begin
            hi_d   = '0;
            lo_d   = cond_neg(sa, a_i);
            opnd_d = cond_neg(sb, b_i);
            f3_d   = funct3_i;
            neg_d  = sa ^ sb;
            rneg_d = sa;
            bz_d   = (b_i == '0);
        end else if (step_i) begin
            hi_d = hi_n;
            lo_d = lo_n;
        end
    end

    // Result as it stands after this cycle's step, so the top can capture it on the last one.
    always_comb begin
        prod = cond_neg2(neg_q, {hi_n, lo_n});
        quo  = bz_q ? ALL_ONES[NBits-1:0] : cond_neg(neg_q, lo_n);
        rem  = cond_neg(rneg_q, hi_n);
        case (f3_q)
            F_MUL:                    res_o = prod[NBits-1:0];
            F_MULH, F_MULHSU, F_MULHU: res_o = prod[2*NBits-1:NBits];
            F_DIV, F_DIVU:            res_o = quo;
            default:                  res_o = rem;
        endcase
    end

    always_ff @(posedge clk) begin
        hi_q   <= hi_d;
        lo_q   <= lo_d;
        opnd_q <= opnd_d;
        f3_q   <= f3_d;
        neg_q  <= neg_d;
        rneg_q <= rneg_d;
        bz_q   <= bz_d;
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle sequencer: FSM, iteration counter, core stall and result register.
// Define MULDIV_EARLY_OUT_EN to finish zero-operand cases directly from IDLE.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int NBits = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [2:0]       funct3_i,
    input  logic [NBits-1:0] a_i,
    input  logic [NBits-1:0] b_i,
    output logic             stall_o,
    output logic             done_o,
    output logic             busy_o,
    output logic [NBits-1:0] result_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NBits-1:0] result_q, result_d;
    logic [NBits-1:0] core_res;
    logic             load, step;

    muldiv_iter_core #(.NBits(NBits)) u_core (
        .clk      (clk),
        .load_i   (load),
        .step_i   (step),
        .funct3_i (funct3_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .res_o    (core_res)
    );

`ifdef MULDIV_EARLY_OUT_EN
    logic             early_hit;
    logic [NBits-1:0] early_res;

    always_comb begin
        early_hit = funct3_i[2] ? (b_i == '0) : (a_i == '0 || b_i == '0);
        if (!funct3_i[2])     early_res = '0;
        else if (funct3_i[1]) early_res = a_i;
        else                  early_res = ALL_ONES[NBits-1:0];
    end
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        load     = 1'b0;
        step     = 1'b0;
        stall_o  = 1'b0;
        done_o   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    load    = 1'b1;
                    stall_o = 1'b1;
                    cnt_d   = '0;
`ifdef MULDIV_EARLY_OUT_EN
                    if (early_hit) begin
                        state_d  = S_DONE;
                        result_d = early_res;
                    end else begin
                        state_d = S_CALC;
                    end
`else
                    state_d = S_CALC;
`endif
                end
            end
            S_CALC: begin
                stall_o = 1'b1;
                step    = 1'b1;
                cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_W'(NBits - 1)) begin
                    state_d  = S_DONE;
                    result_d = core_res;
                end
            end
            // DONE never restarts, even with start_i still asserted.
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o   = (state_q != S_IDLE);
    assign result_o = result_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed RV32M vectors, latency/stall
// checks, mid-operation reset and back-to-back held start.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] a_i, b_i;
    logic        stall_o, done_o, busy_o;
    logic [31:0] result_o;

    int total = 0;
    int bad   = 0;
    int op_id = 0;

    typedef struct {
        logic [31:0] v;
        int          id;
    } exp_t;
    exp_t sb_q[$];

    muldiv_sequencer #(.NBits(32), .CNT_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .start_i  (start_i),
        .funct3_i (funct3_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .busy_o   (busy_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int lat_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if ((f[2] && b == 32'd0) || (!f[2] && (a == 32'd0 || b == 32'd0))) return 2;
`endif
        return 34;
    endfunction

    // Monitor: compare every done_o cycle against the scoreboard head.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (done_o) begin
            exp_t e;
            chk("done_width", {31'd0, prev_done}, 32'd0);
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got result %h expected no completion", result_o);
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("result_op%0d", e.id), result_o, e.v);
            end
        end
        prev_done = done_o;
    end

    // Called at 1 time unit after a rising edge with the FSM in IDLE.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit hold);
        int  lat, cyc, stalls;
        bit  seen;
        exp_t e;
        lat  = lat_of(f, a, b);
        e.v  = exp;
        e.id = op_id;
        sb_q.push_back(e);
        start_i  = 1'b1;
        funct3_i = f;
        a_i      = a;
        b_i      = b;
        cyc = 0; stalls = 0; seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (stall_o) stalls++;
            if (done_o) seen = 1'b1;
            @(posedge clk);
            #1;
            if (cyc == 1) begin
                if (!hold) start_i = 1'b0;
                a_i      = ~a;
                b_i      = a ^ b ^ 32'h5A5A_0001;
                funct3_i = ~f;
            end
        end
        chk($sformatf("done_seen_op%0d", op_id), {31'd0, seen}, 32'd1);
        chk($sformatf("latency_op%0d", op_id), cyc, lat);
        chk($sformatf("stalls_op%0d", op_id), stalls, lat - 1);
        op_id++;
    endtask

    initial begin
        reset = 1'b1; start_i = 1'b0; funct3_i = 3'd0; a_i = '0; b_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall",  {31'd0, stall_o}, 32'd0);
        chk("rst_done",   {31'd0, done_o},  32'd0);
        chk("rst_busy",   {31'd0, busy_o},  32'd0);
        chk("rst_result", result_o, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        do_op(F_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        do_op(F_MULH,   INT_MIN,        INT_MIN,       32'h4000_0000, 1'b0);
        do_op(F_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        do_op(F_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(F_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0);
        do_op(F_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0);
        do_op(F_DIVU,   32'd7,          32'd2,         32'd3,         1'b0);
        do_op(F_REMU,   32'd7,          32'd2,         32'd1,         1'b0);
        do_op(F_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1'b0);
        do_op(F_REMU,   32'd5,          32'd0,         32'd5,         1'b0);
        do_op(F_DIV,    INT_MIN,        32'hFFFF_FFFF, INT_MIN,       1'b0);
        do_op(F_REM,    INT_MIN,        32'hFFFF_FFFF, 32'd0,         1'b0);
        do_op(F_DIV,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, 1'b0);
        do_op(F_REM,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1'b0);
        do_op(F_MULHU,  32'h1234_5678,  32'h0001_0000, 32'h0000_1234, 1'b0);

        // Abort at counter 10: no scoreboard entry, the op never completes.
        start_i = 1'b1; funct3_i = F_MUL; a_i = 32'd3; b_i = 32'd5;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (10) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("abort_stall",  {31'd0, stall_o}, 32'd0);
        chk("abort_busy",   {31'd0, busy_o},  32'd0);
        chk("abort_done",   {31'd0, done_o},  32'd0);
        chk("abort_result", result_o, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        do_op(F_MUL, 32'd3, 32'd5, 32'd15, 1'b0);

        // Back-to-back with start_i held through DONE.
        do_op(F_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
        do_op(F_MUL, 32'd6, 32'd7,         32'd42,        1'b0);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU; replaces the combinational multiplier path at the register-file write mux.
- Sits beside ALU; start comes from Control Mul output ANDed with instruction bit 25.
- Stalls the single-cycle core (PC hold, reg-write suppress) until the result is ready; radix-2 iterative engine, one bit per cycle.

Parameters:
- NBits, 32, operand/result width; only 32 is verified.
- CNT_W, 5, iteration counter width, equal to log2(NBits).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; returns block to IDLE
- start_i  in  1  M-extension instruction decoded this cycle
- funct3_i  in  3  instruction[14:12], selects operation
- a_i  in  NBits  rs1 data
- b_i  in  NBits  rs2 data
- stall_o  out  1  hold PC and block register write; combinational
- done_o  out  1  result valid; enables writeback this cycle
- busy_o  out  1  state != IDLE
- result_o  out  NBits  registered result, held until the next start

Behaviour:
- Reset values: state IDLE, stall_o 0, done_o 0, busy_o 0, result_o 0, counter 0.
- States:
  - IDLE: on start_i, capture funct3, |a|, |b|, sign flags; go to CALC with counter 0.
  - CALC: one iteration per cycle; at counter 31, write result_o and go to DONE.
  - DONE: done_o=1, stall_o=0; always returns to IDLE, even if start_i is still high. The same instruction is never restarted.
- stall_o = (IDLE & start_i) | CALC. done_o = DONE. DONE is unstalled, so the write and PC advance occur at the edge ending DONE.
- Latency: start cycle + 32 CALC + 1 DONE = 34 cycles per instruction, 33 stalled.
- Operands are sampled only in IDLE; a_i/b_i/funct3_i are ignored while busy.
- Sign handling:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU/DIVU/REMU: both unsigned.
- Multiply: unsigned shift-add into a 64-bit accumulator; negate if signs differ. MUL returns [31:0]; MULH* return [63:32].
- Divide: restoring, quotient/remainder 32 bits each.
  - Quotient negated if signs differ.
  - Remainder takes the dividend's sign.
- Divide-by-zero: quotient all ones, remainder = dividend, any signedness.
- Signed overflow (0x80000000 / -1): quotient 0x80000000, remainder 0.
- Reset mid-operation: immediate abort; outputs at reset values; the next start pays full latency.
- start_i in CALC/DONE is ignored. No exceptions or flags.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: if b==0 for divide/remainder, or a==0 or b==0 for multiply, IDLE goes directly to DONE with the special-case result. Latency 2 cycles, 1 stalled.
- Undefined: all operations take the full 34 cycles; results are identical either way.

Decomposition:
- Package muldiv_pkg:
  - funct3 localparams (MUL=0 … REMU=7).
  - State encoding IDLE/CALC/DONE.
  - Constants ALL_ONES and INT_MIN.
- Sub-module muldiv_iter_core: accumulator/quotient/remainder shift registers, one iteration step, final sign fix.
- The top holds the FSM, counter, stall/done logic and result register.

Test Plan:
- MUL 7 × -3: stall_o high 33 cycles, done_o in cycle 34, result_o 0xFFFFFFEB.
- High-half multiplies:
  - MULH 0x80000000×0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- Signed divide: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 7/2 -> 3; REMU 7/2 -> 1.
- Corner cases:
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
  - With MULDIV_EARLY_OUT_EN, the divide-by-zero cases assert done_o in cycle 2.
- Reset at CALC counter 10: stall_o/busy_o/done_o drop asynchronously and result_o=0. A new start completes after 34 cycles.
- Back-to-back MUL instructions with start_i held through DONE: no restart in DONE. The second op begins in the following IDLE cycle; each done_o is exactly one cycle wide.
